// File: rtl/gcd_pkg.sv
// Shared types and width helpers for the binary GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  // Iteration counter width: CALC never runs longer than 4*w cycles.
  function automatic int cnt_width(input int w);
    return $clog2(4 * w + 1);
  endfunction

  function automatic int shift_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational Stein step: halve even operands or subtract the smaller odd one.
module gcd_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             k_inc,
  output logic             equal
);

  // Select exactly one of the four reduction cases.
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_inc = 1'b0;
    equal = (a == b);
    if (equal) begin
      a_nxt = a;
      b_nxt = b;
    end else if (!a[0] && !b[0]) begin
      a_nxt = a >> 1;
      b_nxt = b >> 1;
      k_inc = 1'b1;
    end else if (!a[0]) begin
      a_nxt = a >> 1;
    end else if (!b[0]) begin
      b_nxt = b >> 1;
    end else if (a > b) begin
      a_nxt = a - b;
    end else begin
      b_nxt = b - a;
    end
  end

endmodule

// File: rtl/gcd_stream.sv
// Binary GCD engine with valid/ready handshakes; one Stein step per CALC cycle,
// result held in DONE until the consumer takes it.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             coprime,
  output logic             zero_in,
  output logic [CW-1:0]    cycles
);

  localparam int KW = shift_width(WIDTH);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             coprime_q, coprime_d;
  logic             zero_in_q, zero_in_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [WIDTH-1:0] a_nxt, b_nxt, gcd_val;
  logic             k_inc, equal;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_q),
    .b     (b_q),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .k_inc (k_inc),
    .equal (equal)
  );

  // The gcd divides both inputs, so restoring the common factor 2^k cannot overflow.
  assign gcd_val = a_q << k_q;

  // Next-state, datapath and result-register updates.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    coprime_d = coprime_q;
    zero_in_d = zero_in_q;
    cycles_d  = cycles_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = u;
          b_d   = v;
          k_d   = '0;
          cnt_d = '0;
          if ((u == '0) || (v == '0)) begin
            res_d     = u | v;
            coprime_d = ((u | v) == WIDTH'(1));
            zero_in_d = 1'b1;
            cycles_d  = '0;
            state_d   = DONE;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (equal) begin
          res_d     = gcd_val;
          coprime_d = (gcd_val == WIDTH'(1));
          zero_in_d = 1'b0;
          cycles_d  = cnt_q + CW'(1);
          state_d   = DONE;
        end else begin
          a_d = a_nxt;
          b_d = b_nxt;
          k_d = k_q + KW'(k_inc);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      coprime_q <= 1'b0;
      zero_in_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      coprime_q <= coprime_d;
      zero_in_q <= zero_in_d;
      cycles_q  <= cycles_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign coprime   = coprime_q;
  assign zero_in   = zero_in_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and random checks of gcd_stream at WIDTH=8 and WIDTH=16.
module tb_gcd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, sel16;
  logic [15:0] u_s, v_s;

  logic       ir8, ov8, cp8, zi8;
  logic [7:0] res8;
  logic [5:0] cyc8;
  logic        ir16, ov16, cp16, zi16;
  logic [15:0] res16;
  logic [6:0]  cyc16;

  gcd_stream #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel16), .in_ready(ir8),
    .u(u_s[7:0]), .v(v_s[7:0]), .out_valid(ov8), .out_ready(out_ready | sel16),
    .res(res8), .coprime(cp8), .zero_in(zi8), .cycles(cyc8)
  );

  gcd_stream #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel16), .in_ready(ir16),
    .u(u_s), .v(v_s), .out_valid(ov16), .out_ready(out_ready | ~sel16),
    .res(res16), .coprime(cp16), .zero_in(zi16), .cycles(cyc16)
  );

  logic        m_in_ready, m_out_valid, m_coprime, m_zero_in;
  logic [15:0] m_res;
  logic [31:0] m_cycles;
  assign m_in_ready  = sel16 ? ir16 : ir8;
  assign m_out_valid = sel16 ? ov16 : ov8;
  assign m_coprime   = sel16 ? cp16 : cp8;
  assign m_zero_in   = sel16 ? zi16 : zi8;
  assign m_res       = sel16 ? res16 : {8'h00, res8};
  assign m_cycles    = sel16 ? {25'd0, cyc16} : {26'd0, cyc8};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t = 0;
    @(negedge clk);
    while (!m_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready", {31'd0, m_in_ready}, 32'd1);
    u_s = a;
    v_s = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!m_out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid", {31'd0, m_out_valid}, 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("back_idle", {31'd0, m_in_ready}, 32'd1);
  endtask

  task automatic sweep(input int w, input int n);
    logic [15:0] mask, a, b, exp;
    int lat, hold;
    mask = (w == 8) ? 16'h00FF : 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom) & mask;
      b = 16'($urandom) & mask;
      if ($urandom_range(0, 7) == 0) a = 16'd0;
      exp = ref_gcd(a, b);
      send(a, b);
      wait_done(lat);
      check("rnd_res", {16'd0, m_res}, {16'd0, exp});
      check("rnd_cyc_bound", (m_cycles <= 32'(4 * w)) ? 32'd1 : 32'd0, 32'd1);
      hold = $urandom_range(0, 3);
      for (int j = 0; j < hold; j++) begin
        @(posedge clk);
        #1;
        check("rnd_stable", {16'd0, m_res}, {16'd0, exp});
      end
      consume();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel16 = 1'b0;
    u_s = 16'd0; v_s = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, m_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("rst_res", {16'd0, m_res}, 32'd0);
    check("rst_cycles", m_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    send(16'd48, 16'd18); wait_done(lat);
    check("48_18_res", {16'd0, m_res}, 32'd6);
    check("48_18_coprime", {31'd0, m_coprime}, 32'd0);
    check("48_18_zero_in", {31'd0, m_zero_in}, 32'd0);
    check("48_18_cycles", m_cycles, 32'd7);
    check("48_18_latency", 32'(lat), 32'd8);
    consume();

    send(16'd128, 16'd64); wait_done(lat);
    check("128_64_res", {16'd0, m_res}, 32'd64);
    check("128_64_cycles", m_cycles, 32'd8);
    consume();

    send(16'd35, 16'd64); wait_done(lat);
    check("35_64_res", {16'd0, m_res}, 32'd1);
    check("35_64_coprime", {31'd0, m_coprime}, 32'd1);
    check("35_64_cycles", m_cycles, 32'd14);
    consume();

    send(16'd17, 16'd17); wait_done(lat);
    check("17_17_res", {16'd0, m_res}, 32'd17);
    check("17_17_cycles", m_cycles, 32'd1);
    consume();

    send(16'd0, 16'd9); wait_done(lat);
    check("0_9_res", {16'd0, m_res}, 32'd9);
    check("0_9_zero_in", {31'd0, m_zero_in}, 32'd1);
    check("0_9_cycles", m_cycles, 32'd0);
    check("0_9_latency", 32'(lat), 32'd1);
    consume();

    send(16'd0, 16'd0); wait_done(lat);
    check("0_0_res", {16'd0, m_res}, 32'd0);
    check("0_0_zero_in", {31'd0, m_zero_in}, 32'd1);
    check("0_0_latency", 32'(lat), 32'd1);
    consume();

    // Backpressure with an ignored input pulse while DONE.
    send(16'd48, 16'd18); wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        u_s = 16'd5; v_s = 16'd5; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_res", {16'd0, m_res}, 32'd6);
      check("bp_out_valid", {31'd0, m_out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, m_in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume();
    send(16'd17, 16'd17); wait_done(lat);
    check("after_bp_res", {16'd0, m_res}, 32'd17);
    check("after_bp_latency", 32'(lat), 32'd2);
    consume();

    // Asynchronous reset in the middle of a long computation.
    send(16'd255, 16'd1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, m_in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("mid_rst_res", {16'd0, m_res}, 32'd0);
    check("mid_rst_coprime", {31'd0, m_coprime}, 32'd0);
    check("mid_rst_zero_in", {31'd0, m_zero_in}, 32'd0);
    check("mid_rst_cycles", m_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (m_out_valid) seen++;
    end
    check("mid_rst_no_emit", 32'(seen), 32'd0);
    send(16'd12, 16'd8); wait_done(lat);
    check("12_8_res", {16'd0, m_res}, 32'd4);
    consume();

    sel16 = 1'b0;
    sweep(8, 30);
    sel16 = 1'b1;
    sweep(16, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
